// File: rtl/mips16_hazard_pkg.sv
// Shared types for the MIPS16 ID-stage interlock.
// Holds the FSM state encoding, the scoreboard entry layout and the R0 constant.
package mips16_hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] dest;
    } sb_entry_t;

    localparam logic [2:0] REG_ZERO = 3'd0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes (entry 0 = EX) plus RAW match.
// Ports: clk, rst, shift_vld/shift_dest (new entry), src1/src2 + used flags, hit.
module hazard_scoreboard
    import mips16_hazard_pkg::*;
#(
    parameter int SB_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_vld,
    input  logic [2:0] shift_dest,
    input  logic [2:0] src1,
    input  logic [2:0] src2,
    input  logic       src1_used,
    input  logic       src2_used,
    output logic       hit
);

    sb_entry_t [SB_DEPTH-1:0] sb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb[0].valid <= shift_vld;
            sb[0].dest  <= shift_vld ? shift_dest : REG_ZERO;
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb[i].valid) begin
                if (src1_used && sb[i].dest == src1) hit = 1'b1;
                if (src2_used && sb[i].dest == src2) hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage interlock and branch flush sequencer (no forwarding).
// Ports: clk, rst, ID operand/writeback info, branch_taken; decode enable,
// bubble, IF flush and saturating stall/flush counters.
module id_hazard_ctrl
    import mips16_hazard_pkg::*;
#(
    parameter int SB_DEPTH = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       decoding_op_src1,
    input  logic [2:0]       decoding_op_src2,
    input  logic             src1_used,
    input  logic             src2_used,
    input  logic             issue_wb_en,
    input  logic [2:0]       issue_wb_dest,
    input  logic             branch_taken,
    output logic             instruction_decode_en,
    output logic             id_bubble,
    output logic             if_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e state, state_nxt;
    logic        hit;
    logic        hazard;
    logic        issue_vld;

    // Only a real instruction leaving ID claims a scoreboard slot;
    // stalls and the squashed slot after a flush shift in bubbles.
    assign issue_vld = issue_wb_en
                     && (issue_wb_dest != REG_ZERO)
                     && instruction_decode_en
                     && !id_bubble;

    hazard_scoreboard #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .shift_vld  (issue_vld),
        .shift_dest (issue_wb_dest),
        .src1       (decoding_op_src1),
        .src2       (decoding_op_src2),
        .src1_used  (src1_used),
        .src2_used  (src2_used),
        .hit        (hit)
    );

    // The instruction sitting in ID during FLUSH is squashed,
    // so its operands cannot create a hazard.
    assign hazard = hit && (state != FLUSH);

    always_comb begin
        state_nxt             = state;
        instruction_decode_en = 1'b1;
        id_bubble             = 1'b0;
        if_flush              = 1'b0;
        unique case (state)
            RUN, STALL: begin
                if (hazard) begin
                    instruction_decode_en = 1'b0;
                    id_bubble             = 1'b1;
                    state_nxt             = STALL;
                end else if (branch_taken) begin
                    if_flush  = 1'b1;
                    state_nxt = FLUSH;
                end else begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                id_bubble = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        if (rst) begin
            instruction_decode_en = 1'b0;
            id_bubble             = 1'b1;
            if_flush              = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (hazard && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (if_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: default instance plus a CNT_W=4 copy.
// Ports driven from one stimulus process; outputs checked away from clk edges.
module tb_id_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic        u1;
    logic        u2;
    logic        wen;
    logic [2:0]  wdst;
    logic        br;

    logic        en;
    logic        bub;
    logic        fl;
    logic [15:0] scnt;
    logic [15:0] fcnt;

    logic        en_s;
    logic        bub_s;
    logic        fl_s;
    logic [3:0]  scnt_s;
    logic [3:0]  fcnt_s;

    int chk_cnt;
    int pass_cnt;

    id_hazard_ctrl #(
        .SB_DEPTH (3),
        .CNT_W    (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .decoding_op_src1      (src1),
        .decoding_op_src2      (src2),
        .src1_used             (u1),
        .src2_used             (u2),
        .issue_wb_en           (wen),
        .issue_wb_dest         (wdst),
        .branch_taken          (br),
        .instruction_decode_en (en),
        .id_bubble             (bub),
        .if_flush              (fl),
        .stall_cnt             (scnt),
        .flush_cnt             (fcnt)
    );

    id_hazard_ctrl #(
        .SB_DEPTH (3),
        .CNT_W    (4)
    ) dut_s (
        .clk                   (clk),
        .rst                   (rst),
        .decoding_op_src1      (src1),
        .decoding_op_src2      (src2),
        .src1_used             (u1),
        .src2_used             (u2),
        .issue_wb_en           (wen),
        .issue_wb_dest         (wdst),
        .branch_taken          (br),
        .instruction_decode_en (en_s),
        .id_bubble             (bub_s),
        .if_flush              (fl_s),
        .stall_cnt             (scnt_s),
        .flush_cnt             (fcnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s1,
                         input logic [2:0] s2,
                         input logic       a1,
                         input logic       a2,
                         input logic       we,
                         input logic [2:0] wd,
                         input logic       b);
        src1 = s1;
        src2 = s2;
        u1   = a1;
        u2   = a2;
        wen  = we;
        wdst = wd;
        br   = b;
    endtask

    task automatic idle;
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst      = 1'b1;
        idle();

        // reset values
        #2;
        chk("rst_en", {15'd0, en}, 16'd0);
        chk("rst_bub", {15'd0, bub}, 16'd1);
        chk("rst_fl", {15'd0, fl}, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rel_en", {15'd0, en}, 16'd1);
        chk("rel_bub", {15'd0, bub}, 16'd0);
        chk("rel_scnt", scnt, 16'd0);
        chk("rel_fcnt", fcnt, 16'd0);

        // RAW on R3, producer in EX -> 3 stall cycles
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        #1;
        chk("prod_en", {15'd0, en}, 16'd1);
        tick();
        drive(3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("raw_en1", {15'd0, en}, 16'd0);
        chk("raw_bub1", {15'd0, bub}, 16'd1);
        tick();
        chk("raw_en2", {15'd0, en}, 16'd0);
        tick();
        chk("raw_en3", {15'd0, en}, 16'd0);
        chk("raw_bub3", {15'd0, bub}, 16'd1);
        tick();
        chk("raw_en4", {15'd0, en}, 16'd1);
        chk("raw_bub4", {15'd0, bub}, 16'd0);
        chk("raw_scnt", scnt, 16'd3);
        tick();

        // R0 writes never hazard
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        tick();
        drive(3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("r0_en", {15'd0, en}, 16'd1);

        // unused src2 matching a pending write
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        drive(3'd0, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("unused_en", {15'd0, en}, 16'd1);
        chk("unused_scnt", scnt, 16'd3);
        idle();
        tick();
        tick();
        tick();

        // taken branch, no hazard
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        #1;
        chk("br_fl", {15'd0, fl}, 16'd1);
        chk("br_en", {15'd0, en}, 16'd1);
        chk("br_bub", {15'd0, bub}, 16'd0);
        tick();
        chk("flush_bub", {15'd0, bub}, 16'd1);
        chk("flush_fl", {15'd0, fl}, 16'd0);
        chk("flush_en", {15'd0, en}, 16'd1);
        chk("flush_cnt1", fcnt, 16'd1);
        idle();
        tick();
        chk("post_bub", {15'd0, bub}, 16'd0);
        chk("post_fcnt", fcnt, 16'd1);

        // branch while src1 pending on R5
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        tick();
        drive(3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
        #1;
        chk("bh_en1", {15'd0, en}, 16'd0);
        chk("bh_fl1", {15'd0, fl}, 16'd0);
        tick();
        chk("bh_fl2", {15'd0, fl}, 16'd0);
        tick();
        chk("bh_fl3", {15'd0, fl}, 16'd0);
        tick();
        chk("bh_en4", {15'd0, en}, 16'd1);
        chk("bh_fl4", {15'd0, fl}, 16'd1);
        tick();
        chk("bh_bub", {15'd0, bub}, 16'd1);
        chk("bh_fcnt", fcnt, 16'd2);
        chk("bh_scnt", scnt, 16'd6);
        idle();
        tick();

        // producer one slot ahead (in MEM) on src2 -> 2 stalls
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
        tick();
        idle();
        tick();
        drive(3'd0, 3'd4, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        #1;
        chk("mem_en1", {15'd0, en}, 16'd0);
        tick();
        chk("mem_en2", {15'd0, en}, 16'd0);
        tick();
        chk("mem_en3", {15'd0, en}, 16'd1);
        chk("mem_scnt", scnt, 16'd8);
        idle();
        tick();

        // async reset mid-stall discards pending writes
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        tick();
        drive(3'd6, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("mid_en", {15'd0, en}, 16'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_en", {15'd0, en}, 16'd0);
        chk("mid_rst_bub", {15'd0, bub}, 16'd1);
        chk("mid_rst_scnt", scnt, 16'd0);
        chk("mid_rst_fcnt", fcnt, 16'd0);
        rst = 1'b0;
        #1;
        chk("mid_rel_en", {15'd0, en}, 16'd1);
        idle();
        tick();
        tick();
        tick();

        // 21 stall cycles: 4-bit counter saturates
        for (int r = 0; r < 7; r++) begin
            drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
            tick();
            drive(3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
            tick();
            tick();
            tick();
            tick();
        end
        idle();
        chk("sat_small", {12'd0, scnt_s}, 16'h000f);
        chk("sat_big", scnt, 16'd21);
        chk("sat_fcnt", {12'd0, fcnt_s}, 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
